// File: rtl/z_mon_pkg.sv
// Shared types, default sizes and helpers for the z-run monitor.
package z_mon_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int TOT_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/z_run_monitor_if.sv
// Detector-side inputs and host-side drain/status signals of the z-run monitor.
interface z_run_monitor_if
    import z_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOT_W = TOT_W_DEF
);
    logic             z_in;
    logic             en;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_len;
    logic [TOT_W-1:0] total_runs;
    logic             ovf;
    logic             active;

    modport master (
        output z_in, en, out_ready,
        input  out_valid, out_len, total_runs, ovf, active
    );

    modport slave (
        input  z_in, en, out_ready,
        output out_valid, out_len, total_runs, ovf, active
    );
endinterface

// File: rtl/run_len_fifo.sv
// Small register-file FIFO with wrap-bit pointers; a push into a full FIFO
// is accepted only when a pop frees the head slot on the same edge.
module run_len_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: the array is tiny and its head drives an output, so it is reset
    // to keep out_len at zero after reset; large memories are left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/z_run_monitor.sv
// Measures runs of consecutive high z samples and queues completed run lengths
// for the host, with a saturating completed-run total and a sticky drop flag.
module z_run_monitor
    import z_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TOT_W = TOT_W_DEF
) (
    input logic            clk,
    input logic            rst_n,
    z_run_monitor_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic             ovf_q, ovf_d;

    logic             hit, complete, pop, full, empty;
    logic [CNT_W-1:0] head;

    assign hit = bus.en & bus.z_in;
    assign pop = ~empty & bus.out_ready;

    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        complete  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d   = RUN;
                    run_cnt_d = CNT_W'(1);
                end
            end
            RUN: begin
                if (hit) begin
                    run_cnt_d = CNT_W'(sat_inc(32'(run_cnt_q), CNT_W));
                end else begin
                    // The terminating sample (low z or enable dropped) is not counted.
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        total_d = complete ? TOT_W'(sat_inc(32'(total_q), TOT_W)) : total_q;
        // A completion is lost only when the FIFO is full and no pop frees a slot.
        ovf_d   = ovf_q | (complete & full & ~pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            total_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            total_q   <= total_d;
            ovf_q     <= ovf_d;
        end
    end

    run_len_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (complete),
        .push_data_i (run_cnt_q),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head)
    );

    assign bus.out_valid  = ~empty;
    assign bus.out_len    = head;
    assign bus.total_runs = total_q;
    assign bus.ovf        = ovf_q;
    assign bus.active     = (state_q == RUN);

endmodule

// File: tb/tb_z_run_monitor.sv
// Self-checking bench for z_run_monitor: vector table plus directed sequences,
// with a run-length scoreboard checked on every handshake.
module tb_z_run_monitor;

    localparam int CNT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int TOT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TOT_MAX = (1 << TOT_W) - 1;

    logic clk;
    logic rst_n;

    z_run_monitor_if #(.CNT_W(CNT_W), .TOT_W(TOT_W)) bus ();

    z_run_monitor #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH),
        .TOT_W (TOT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, advanced once per driven cycle.
    int m_cnt   = 0;
    bit m_run   = 1'b0;
    int m_occ   = 0;
    int m_total = 0;
    bit m_ovf   = 1'b0;
    int exp_q[$];

    typedef struct {
        logic z;
        logic en;
        logic rdy;
        logic a;
        logic v;
        int   len;
        int   tot;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt   = 0;
        m_run   = 1'b0;
        m_occ   = 0;
        m_total = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle, predict its effect, then wait past the edge.
    task automatic step(input logic z, input logic e, input logic r);
        bit pop;
        bit done;
        bus.z_in      = z;
        bus.en        = e;
        bus.out_ready = r;
        pop  = (m_occ != 0) && r;
        done = m_run && !(z && e);
        if (done) begin
            m_total = (m_total == TOT_MAX) ? m_total : m_total + 1;
            if (m_occ < DEPTH || pop) begin
                exp_q.push_back(m_cnt);
                m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) m_occ--;
        if (z && e) begin
            m_cnt = !m_run ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
            m_run = 1'b1;
        end else begin
            m_run = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_active"}, 32'(bus.active), 32'(m_run));
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_occ != 0));
        check({tag, "_total"}, 32'(bus.total_runs), 32'(m_total));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_len"}, 32'(bus.out_len), 32'd0);
        check({tag, "_total"}, 32'(bus.total_runs), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        check({tag, "_active"}, 32'(bus.active), 32'd0);
    endtask

    // Called just after an edge: pulse reset between edges, release before the next.
    task automatic reset_between_edges(input string tag);
        #2 rst_n = 1'b0;
        bus.z_in      = 1'b0;
        bus.en        = 1'b1;
        bus.out_ready = 1'b0;
        model_clear();
        #1 check_zero(tag);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a handshake visible at the falling edge pops on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL pop_len: got %0d expected no entry", bus.out_len);
            end else begin
                check("pop_len", 32'(bus.out_len), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // z, en, rdy, active, valid, len, total
        vecs[0]  = '{0, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 1, 0, 0, 0};
        vecs[2]  = '{1, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{1, 1, 1, 1, 0, 0, 0};
        vecs[4]  = '{0, 1, 1, 0, 1, 3, 1};
        vecs[5]  = '{0, 1, 1, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 0, 1, 0, 0, 1};
        vecs[7]  = '{0, 1, 0, 0, 1, 1, 2};
        vecs[8]  = '{1, 1, 0, 1, 1, 1, 2};
        vecs[9]  = '{1, 1, 0, 1, 1, 1, 2};
        vecs[10] = '{0, 1, 0, 0, 1, 1, 3};
        vecs[11] = '{1, 1, 0, 1, 1, 1, 3};
        vecs[12] = '{0, 1, 0, 0, 1, 1, 4};
        vecs[13] = '{0, 1, 1, 0, 1, 2, 4};
        vecs[14] = '{0, 1, 1, 0, 1, 1, 4};
        vecs[15] = '{0, 1, 1, 0, 0, 0, 4};
        vecs[16] = '{0, 1, 1, 0, 0, 0, 4};

        rst_n         = 1'b0;
        bus.z_in      = 1'b0;
        bus.en        = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 check_zero("por");
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic run, back-to-back runs, then drain.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].z, vecs[i].en, vecs[i].rdy);
            check($sformatf("vec%0d_active", i), 32'(bus.active), 32'(vecs[i].a));
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].v));
            check($sformatf("vec%0d_total", i), 32'(bus.total_runs), 32'(vecs[i].tot));
            if (vecs[i].v) begin
                check($sformatf("vec%0d_len", i), 32'(bus.out_len), 32'(vecs[i].len));
            end
        end

        // Overflow: four kept, fifth dropped, sixth accepted alongside a pop.
        reset_between_edges("rst_ovf");
        for (int r = 0; r < 4; r++) begin
            step(1, 1, 0);
            step(0, 1, 0);
        end
        check("ovf_full_no_drop", 32'(bus.ovf), 32'd0);
        step(1, 1, 0);
        step(0, 1, 0);
        check("ovf_set", 32'(bus.ovf), 32'd1);
        check("ovf_total5", 32'(bus.total_runs), 32'd5);
        check_model("ovf5");
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 1, 1);
        check("ovf_sticky", 32'(bus.ovf), 32'd1);
        check("ovf_total6", 32'(bus.total_runs), 32'd6);
        check_model("ovf6");
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        check("ovf_drained", 32'(bus.out_valid), 32'd0);
        check("ovf_still_set", 32'(bus.ovf), 32'd1);

        // Run-length saturation.
        reset_between_edges("rst_sat");
        for (int i = 0; i < 300; i++) step(1, 1, 1);
        check("sat_active", 32'(bus.active), 32'd1);
        step(0, 1, 1);
        check("sat_valid", 32'(bus.out_valid), 32'd1);
        check("sat_len", 32'(bus.out_len), 32'(CNT_MAX));
        step(0, 1, 1);
        check_model("sat");

        // Enable dropped mid-run ends the run; no restart while disabled.
        reset_between_edges("rst_en");
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        check("en_active", 32'(bus.active), 32'd1);
        step(1, 0, 0);
        check("en_drop_active", 32'(bus.active), 32'd0);
        check("en_drop_valid", 32'(bus.out_valid), 32'd1);
        check("en_drop_len", 32'(bus.out_len), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check($sformatf("en_off%0d_active", i), 32'(bus.active), 32'd0);
        end
        check("en_off_total", 32'(bus.total_runs), 32'd1);
        step(0, 1, 1);
        step(0, 1, 1);
        check_model("en");

        // Asynchronous reset with two queued entries and a run in progress.
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        check_model("pre_rst");
        reset_between_edges("rst_mid");
        step(1, 1, 1);
        step(1, 1, 1);
        step(0, 1, 1);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_len", 32'(bus.out_len), 32'd2);
        step(0, 1, 1);
        check_model("post_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
